// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: program counter, ROM address, instruction register and the
// immediate register for 2-word instructions, driven by the control FSM's PC/IR strobes.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              pc_load,
  input  logic              pc_inc,
  input  logic              ins_load,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [3:0]        opcode,
  output logic [2:0]        op1_addr,
  output logic [2:0]        op2_addr,
  output logic [DATA_W-1:0] imm_data,
  output logic              imm_valid,
  output logic [ADDR_W-1:0] pc_hold,
  output logic              second_word,
  output logic              halted
);

  localparam logic [3:0] OpMvi  = 4'b1100;
  localparam logic [3:0] OpLda  = 4'b1101;
  localparam logic [3:0] OpHalt = 4'b1111;

  typedef enum logic [1:0] {
    StWord0,
    StWord1,
    StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_hold_q, pc_hold_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              imm_valid_q, imm_valid_d;
  logic [3:0]        rom_opcode;

  assign rom_opcode = rom_data[15:12];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_hold_d   = pc_hold_q;
    ir_d        = ir_q;
    imm_d       = imm_q;
    imm_valid_d = imm_valid_q;

    if (!en) begin
      // Dropping enable abandons a pending second word, but never leaves HALT.
      if (state_q != StHalt) begin
        state_d = StWord0;
      end
      imm_valid_d = 1'b0;
    end else begin
      if (pc_load) begin
        pc_hold_d = pc_q;
      end

      if (state_q != StHalt) begin
        if (ins_load) begin
          if (state_q == StWord0) begin
            ir_d        = rom_data;
            imm_valid_d = 1'b0;
            unique case (rom_opcode)
              OpMvi, OpLda: state_d = StWord1;
              OpHalt:       state_d = StHalt;
              default:      state_d = StWord0;
            endcase
          end else begin
            imm_d       = rom_data;
            imm_valid_d = 1'b1;
            state_d     = StWord0;
          end
        end

        // A jump overrides whatever state the captured word selected.
        if (jmp_en) begin
          pc_d        = jmp_addr;
          state_d     = StWord0;
          imm_valid_d = 1'b0;
        end else if (pc_inc) begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWord0;
      pc_q        <= '0;
      pc_hold_q   <= '0;
      ir_q        <= '0;
      imm_q       <= '0;
      imm_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_hold_q   <= pc_hold_d;
      ir_q        <= ir_d;
      imm_q       <= imm_d;
      imm_valid_q <= imm_valid_d;
    end
  end

  assign rom_addr    = pc_q;
  assign opcode      = ir_q[15:12];
  assign op1_addr    = ir_q[11:9];
  assign op2_addr    = ir_q[8:6];
  assign imm_data    = imm_q;
  assign imm_valid   = imm_valid_q;
  assign pc_hold     = pc_hold_q;
  assign second_word = (state_q == StWord1);
  assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a small ROM model and hand-computed expected values.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        pc_load;
  logic        pc_inc;
  logic        ins_load;
  logic        jmp_en;
  logic [7:0]  jmp_addr;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [3:0]  opcode;
  logic [2:0]  op1_addr;
  logic [2:0]  op2_addr;
  logic [15:0] imm_data;
  logic        imm_valid;
  logic [7:0]  pc_hold;
  logic        second_word;
  logic        halted;

  logic [15:0] rom [256];
  int          n_cmp;
  int          n_err;

  instr_fetch_unit #(
    .ADDR_W(8),
    .DATA_W(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pc_load    (pc_load),
    .pc_inc     (pc_inc),
    .ins_load   (ins_load),
    .jmp_en     (jmp_en),
    .jmp_addr   (jmp_addr),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .opcode     (opcode),
    .op1_addr   (op1_addr),
    .op2_addr   (op2_addr),
    .imm_data   (imm_data),
    .imm_valid  (imm_valid),
    .pc_hold    (pc_hold),
    .second_word(second_word),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given strobes; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic ld, input logic inc, input logic ins, input logic jmp,
                     input logic [7:0] ja);
    pc_load  = ld;
    pc_inc   = inc;
    ins_load = ins;
    jmp_en   = jmp;
    jmp_addr = ja;
    @(posedge clk);
    #1;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    ins_load = 1'b0;
    jmp_en   = 1'b0;
    jmp_addr = 8'h00;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h0A40;  // ADD r5,r1
    rom[8'h01] = 16'hC600;  // MVI r3
    rom[8'h02] = 16'h1234;
    rom[8'h03] = 16'h2E80;  // op 2, r7, r2
    rom[8'h10] = 16'hF000;  // HALT

    rst_n    = 1'b0;
    en       = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    ins_load = 1'b0;
    jmp_en   = 1'b0;
    jmp_addr = 8'h00;
    #2;
    check_eq("rst_pc", rom_addr, 0);
    check_eq("rst_second_word", second_word, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_imm_valid", imm_valid, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    en    = 1'b1;

    // 1-word fetch
    cyc(1, 0, 1, 0, 8'h00);
    check_eq("w1_opcode", opcode, 4'h0);
    check_eq("w1_op1", op1_addr, 5);
    check_eq("w1_op2", op2_addr, 1);
    check_eq("w1_pc_hold", pc_hold, 0);
    check_eq("w1_second_word", second_word, 0);
    cyc(0, 1, 0, 0, 8'h00);
    check_eq("w1_pc", rom_addr, 1);

    // 2-word MVI
    cyc(0, 0, 1, 0, 8'h00);
    check_eq("mvi_second_word", second_word, 1);
    check_eq("mvi_opcode0", opcode, 4'hC);
    cyc(0, 1, 0, 0, 8'h00);
    check_eq("mvi_pc2", rom_addr, 2);
    cyc(0, 0, 1, 0, 8'h00);
    check_eq("mvi_imm", imm_data, 16'h1234);
    check_eq("mvi_imm_valid", imm_valid, 1);
    check_eq("mvi_opcode1", opcode, 4'hC);
    check_eq("mvi_second_word_done", second_word, 0);
    cyc(0, 1, 0, 0, 8'h00);
    check_eq("mvi_pc3", rom_addr, 3);

    // en drop after a completed immediate: valid clears, state held otherwise
    en = 1'b0;
    cyc(0, 1, 1, 0, 8'h00);
    en = 1'b1;
    check_eq("endrop0_imm_valid", imm_valid, 0);
    check_eq("endrop0_pc", rom_addr, 3);
    check_eq("endrop0_imm", imm_data, 16'h1234);

    // pc_load + ins_load + pc_inc together at pc=3
    cyc(1, 1, 1, 0, 8'h00);
    check_eq("combo_pc_hold", pc_hold, 3);
    check_eq("combo_pc", rom_addr, 4);
    check_eq("combo_opcode", opcode, 4'h2);
    check_eq("combo_op1", op1_addr, 7);
    check_eq("combo_op2", op2_addr, 2);

    // Jump mid 2-word instruction
    cyc(0, 0, 0, 1, 8'h01);
    cyc(0, 0, 1, 0, 8'h00);
    check_eq("jmid_second_word_pre", second_word, 1);
    cyc(0, 0, 0, 1, 8'h40);
    check_eq("jmid_pc", rom_addr, 8'h40);
    check_eq("jmid_second_word", second_word, 0);
    check_eq("jmid_imm_valid", imm_valid, 0);
    check_eq("jmid_opcode", opcode, 4'hC);
    check_eq("jmid_op1", op1_addr, 3);

    // en drop in WORD1 with strobes asserted
    cyc(0, 0, 0, 1, 8'h01);
    cyc(0, 0, 1, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    en = 1'b0;
    cyc(0, 1, 1, 1, 8'h80);
    en = 1'b1;
    check_eq("endrop1_second_word", second_word, 0);
    check_eq("endrop1_imm_valid", imm_valid, 0);
    check_eq("endrop1_pc", rom_addr, 2);
    check_eq("endrop1_opcode", opcode, 4'hC);
    cyc(0, 0, 1, 0, 8'h00);
    check_eq("endrop1_refetch_opcode", opcode, 4'h1);

    // Wrap-around
    cyc(0, 0, 0, 1, 8'hFF);
    check_eq("wrap_pre", rom_addr, 8'hFF);
    cyc(0, 1, 0, 0, 8'h00);
    check_eq("wrap_pc", rom_addr, 8'h00);

    // HALT word captured together with a jump: no halt
    cyc(0, 0, 0, 1, 8'h10);
    cyc(0, 0, 1, 1, 8'h20);
    check_eq("jhalt_opcode", opcode, 4'hF);
    check_eq("jhalt_halted", halted, 0);
    check_eq("jhalt_pc", rom_addr, 8'h20);

    // HALT
    cyc(0, 0, 0, 1, 8'h10);
    cyc(0, 0, 1, 0, 8'h00);
    check_eq("halt_halted", halted, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 1, 8'h33);
    check_eq("halt_pc_frozen", rom_addr, 8'h10);
    check_eq("halt_still", halted, 1);
    cyc(1, 1, 0, 0, 8'h00);
    check_eq("halt_pc_hold", pc_hold, 8'h10);
    check_eq("halt_pc_frozen2", rom_addr, 8'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_halted", halted, 0);
    check_eq("arst_pc", rom_addr, 0);
    check_eq("arst_pc_hold", pc_hold, 0);
    check_eq("arst_opcode", opcode, 0);
    #3;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of the control-signal FSM.
- Owns the program counter (PC), the instruction ROM address, the instruction register (IR) and the immediate register for 2-word instructions.
- Splits the IR into opcode and register-address fields, which the control FSM and operand stages consume.
- Acts on the control FSM's PC_load, PC_inc and Ins_load strobes.

Parameters:
- ADDR_W, 8: PC and ROM address width.
- DATA_W, 16: instruction word width; fixed at 16 for the field layout below.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  unit enable; same signal that enables the control FSM.
- pc_load  in  1  capture current PC into pc_hold.
- pc_inc  in  1  increment PC.
- ins_load  in  1  capture rom_data into IR or the immediate register.
- jmp_en  in  1  load jmp_addr into PC.
- jmp_addr  in  ADDR_W  jump target.
- rom_addr  out  ADDR_W  instruction ROM address; combinationally equal to PC.
- rom_data  in  DATA_W  asynchronous ROM read data at rom_addr.
- opcode  out  4  IR[15:12].
- op1_addr  out  3  IR[11:9].
- op2_addr  out  3  IR[8:6].
- imm_data  out  DATA_W  second word of MVI/LDA.
- imm_valid  out  1  imm_data captured for the current instruction.
- pc_hold  out  ADDR_W  PC value latched by pc_load.
- second_word  out  1  next ins_load targets the immediate register (state WORD1).
- halted  out  1  HALT opcode fetched; PC frozen.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc, pc_hold, ir, imm all 0.
  - imm_valid=0, state=WORD0, second_word=0, halted=0.
  - Outputs settle immediately, without waiting for clk.
- en low at a clock edge:
  - state goes to WORD0 and imm_valid clears.
  - pc, ir, imm, pc_hold and halted hold.
  - All strobes are ignored.
- States:
  - WORD0: expecting an opcode word.
  - WORD1: expecting the immediate word of a 2-word instruction.
  - HALT: frozen.
- WORD0 with ins_load:
  - ir <= rom_data and imm_valid <= 0.
  - rom_data[15:12] = 4'b1100 (MVI) or 4'b1101 (LDA): go to WORD1.
  - rom_data[15:12] = 4'b1111: go to HALT and set halted.
  - Any other opcode: stay in WORD0.
- WORD1 with ins_load:
  - imm <= rom_data, imm_valid <= 1, go to WORD0.
  - ir is unchanged, so opcode stays MVI/LDA through the 2-word execute cycle.
- HALT: pc_inc, jmp_en and ins_load are ignored. Only reset exits HALT.
- PC update, in priority order:
  1. jmp_en: pc <= jmp_addr, and state forced to WORD0 (a pending second word is abandoned, imm_valid cleared).
  2. pc_inc: pc <= pc+1 modulo 2^ADDR_W; all-ones wraps to 0.
- pc_load: pc_hold <= pc (pre-increment value if pc_inc fires in the same cycle). pc_load is still honoured in HALT.
- Simultaneous ins_load and pc_inc: IR captures data at the old PC; PC then advances.
- Simultaneous ins_load and jmp_en: IR captures data at the old PC; PC takes jmp_addr; state is WORD0 regardless of the opcode captured.
- Latency:
  - opcode, op1_addr and op2_addr are valid the cycle after ins_load.
  - rom_addr follows pc with zero cycles of latency.
- No combinational path from rom_data to any output except through registers.

Test Plan:
- Reset then 1-word fetch: ROM[0]=16'h0A40 (ADD r5,r1). Pulse pc_load+ins_load, then pc_inc. Required: opcode=0, op1_addr=5, op2_addr=1, pc_hold=0, pc=1, second_word stays 0.
- 2-word MVI: ROM[1]=16'hC600, ROM[2]=16'h1234. Run ins_load; pc_inc; ins_load; pc_inc. Required: second_word=1 after the first ins_load, then imm_data=16'h1234, imm_valid=1, opcode still 4'hC, pc=3.
- Wrap-around: ADDR_W=8, PC driven to 8'hFF by jump, pc_inc. Required: pc=0 and rom_addr=0.
- Jump mid 2-word instruction: in WORD1, assert jmp_en with jmp_addr=8'h40. Required: pc=8'h40, second_word=0, imm_valid=0, IR unchanged.
- HALT: ROM[k]=16'hF000, then ins_load. Required: halted=1. Afterwards, 5 pc_inc pulses and one jmp_en leave pc at k; rst_n low clears halted and pc asynchronously, without a clock edge.
- en drop: in WORD1, drop en for one cycle. Required: state WORD0 and imm_valid=0, with pc and ir unchanged.
